// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Stall/flush/forwarding controller for the pipelined MIPS core with caches.
//   A shadow pipeline of destination tags (entry 0 = EXE, 1 = MEM, 2 = WB, ...)
//   is kept internally, so the datapath does not have to feed back per-stage
//   write addresses.
//
//   Inputs : i_clk, i_rst (async, active high), ID instruction description
//            (i_id_valid, i_id_rs/rt, i_id_rs_used/rt_used, i_id_wen, i_id_dst,
//            i_id_is_load), i_jump_en, i_inst_stall, i_mem_stall.
//   Outputs: o_<stage>_en / o_<stage>_rst for if/id/exe/mem/wb, o_ld_use_stall,
//            o_fwd_a_sel/o_fwd_a_ld (RS source), o_fwd_b_sel/o_fwd_b_ld (RT).
//            A select of 0 means register file, k means shadow stage k-1.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to add the saturating 32-bit
//   counters o_cnt_ld_use, o_cnt_mem_stall, o_cnt_inst_stall and o_cnt_flush.
module pipe_hazard_unit #(
    parameter int RA_W   = 5,
    parameter int DEPTH  = 3,
    parameter int LD_LAT = 1,
    parameter int SEL_W  = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_id_valid,
    input  logic [RA_W-1:0] i_id_rs,
    input  logic [RA_W-1:0] i_id_rt,
    input  logic            i_id_rs_used,
    input  logic            i_id_rt_used,
    input  logic            i_id_wen,
    input  logic [RA_W-1:0] i_id_dst,
    input  logic            i_id_is_load,
    input  logic            i_jump_en,
    input  logic            i_inst_stall,
    input  logic            i_mem_stall,
    output logic            o_if_en,
    output logic            o_id_en,
    output logic            o_exe_en,
    output logic            o_mem_en,
    output logic            o_wb_en,
    output logic            o_if_rst,
    output logic            o_id_rst,
    output logic            o_exe_rst,
    output logic            o_mem_rst,
    output logic            o_wb_rst,
    output logic            o_ld_use_stall,
    output logic [SEL_W-1:0] o_fwd_a_sel,
    output logic            o_fwd_a_ld,
    output logic [SEL_W-1:0] o_fwd_b_sel,
    output logic            o_fwd_b_ld
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     o_cnt_ld_use,
    output logic [31:0]     o_cnt_mem_stall,
    output logic [31:0]     o_cnt_inst_stall,
    output logic [31:0]     o_cnt_flush
`endif
);

    // Shadow pipeline, index 0 is the youngest (EXE) entry.
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_wen;
    logic [DEPTH-1:0] r_ld;
    logic [RA_W-1:0]  r_dst [DEPTH];

    logic [DEPTH-1:0] w_hit_a;
    logic [DEPTH-1:0] w_hit_b;
    logic             w_ld_use;
    logic             w_win_mem;
    logic             w_win_inst;
    logic             w_win_ld;
    logic             w_win_flush;
    logic             w_bubble;

    always_comb begin
        w_hit_a = '0;
        w_hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit_a[i] = r_v[i] & r_wen[i] & (r_dst[i] == i_id_rs) &
                         (i_id_rs != '0) & i_id_rs_used;
            w_hit_b[i] = r_v[i] & r_wen[i] & (r_dst[i] == i_id_rt) &
                         (i_id_rt != '0) & i_id_rt_used;
        end
    end

    // Load data is not yet available in stages younger than LD_LAT.
    always_comb begin
        w_ld_use = 1'b0;
        for (int i = 0; i < LD_LAT; i++) begin
            w_ld_use = w_ld_use | ((w_hit_a[i] | w_hit_b[i]) & r_ld[i]);
        end
    end

    assign o_ld_use_stall = w_ld_use;

    // Scan oldest to youngest so the youngest hit is the one left standing.
    always_comb begin
        o_fwd_a_sel = '0;
        o_fwd_a_ld  = 1'b0;
        o_fwd_b_sel = '0;
        o_fwd_b_ld  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_hit_a[i]) begin
                o_fwd_a_sel = SEL_W'(i + 1);
                o_fwd_a_ld  = r_ld[i];
            end
            if (w_hit_b[i]) begin
                o_fwd_b_sel = SEL_W'(i + 1);
                o_fwd_b_ld  = r_ld[i];
            end
        end
        if (w_ld_use) begin
            o_fwd_a_sel = '0;
            o_fwd_a_ld  = 1'b0;
            o_fwd_b_sel = '0;
            o_fwd_b_ld  = 1'b0;
        end
    end

    // Winning condition below reset, in priority order.
    assign w_win_mem   = i_mem_stall;
    assign w_win_inst  = ~i_mem_stall & i_inst_stall;
    assign w_win_ld    = ~i_mem_stall & ~i_inst_stall & w_ld_use;
    assign w_win_flush = ~i_mem_stall & ~i_inst_stall & ~w_ld_use & i_jump_en;
    assign w_bubble    = w_win_inst | w_win_ld;

    always_comb begin
        o_if_en   = 1'b1;
        o_id_en   = 1'b1;
        o_exe_en  = 1'b1;
        o_mem_en  = 1'b1;
        o_wb_en   = 1'b1;
        o_if_rst  = 1'b0;
        o_id_rst  = 1'b0;
        o_exe_rst = 1'b0;
        o_mem_rst = 1'b0;
        o_wb_rst  = 1'b0;
        if (i_rst) begin
            o_if_rst  = 1'b1;
            o_id_rst  = 1'b1;
            o_exe_rst = 1'b1;
            o_mem_rst = 1'b1;
            o_wb_rst  = 1'b1;
        end else if (w_win_mem) begin
            o_if_en  = 1'b0;
            o_id_en  = 1'b0;
            o_exe_en = 1'b0;
            o_mem_en = 1'b0;
            o_wb_en  = 1'b0;
        end else if (w_bubble) begin
            // Hold IF/ID and inject a bubble into EXE.
            o_if_en   = 1'b0;
            o_id_en   = 1'b0;
            o_exe_rst = 1'b1;
        end else if (w_win_flush) begin
            // The jump itself proceeds to EXE; only the slot behind it is killed.
            o_id_rst = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v   <= '0;
            r_wen <= '0;
            r_ld  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dst[i] <= '0;
            end
        end else if (!i_mem_stall) begin
            // The deepest entry falls off the end: it has been retired by WB.
            r_v   <= {r_v[DEPTH-2:0], ~w_bubble & i_id_valid};
            r_wen <= {r_wen[DEPTH-2:0], ~w_bubble & i_id_wen};
            r_ld  <= {r_ld[DEPTH-2:0], ~w_bubble & i_id_is_load};
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_dst[i] <= r_dst[i-1];
            end
            r_dst[0] <= w_bubble ? '0 : i_id_dst;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_cnt_ld_use;
    logic [31:0] r_cnt_mem_stall;
    logic [31:0] r_cnt_inst_stall;
    logic [31:0] r_cnt_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_ld_use     <= '0;
            r_cnt_mem_stall  <= '0;
            r_cnt_inst_stall <= '0;
            r_cnt_flush      <= '0;
        end else begin
            if (w_win_ld && r_cnt_ld_use != '1) begin
                r_cnt_ld_use <= r_cnt_ld_use + 32'd1;
            end
            if (w_win_mem && r_cnt_mem_stall != '1) begin
                r_cnt_mem_stall <= r_cnt_mem_stall + 32'd1;
            end
            if (w_win_inst && r_cnt_inst_stall != '1) begin
                r_cnt_inst_stall <= r_cnt_inst_stall + 32'd1;
            end
            if (w_win_flush && r_cnt_flush != '1) begin
                r_cnt_flush <= r_cnt_flush + 32'd1;
            end
        end
    end

    assign o_cnt_ld_use     = r_cnt_ld_use;
    assign o_cnt_mem_stall  = r_cnt_mem_stall;
    assign o_cnt_inst_stall = r_cnt_inst_stall;
    assign o_cnt_flush      = r_cnt_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit (RA_W=5, DEPTH=3, LD_LAT=1, SEL_W=3).
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus against an in-flight instruction list model.
module tb_pipe_hazard_unit;

    localparam int RA_W   = 5;
    localparam int DEPTH  = 3;
    localparam int LD_LAT = 1;
    localparam int SEL_W  = 3;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       wen;
        logic [4:0] dst;
        logic       is_load;
        logic       jump;
        logic       inst_stall;
        logic       mem_stall;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [18:0] exp;
    } vec_t;

    // One in-flight instruction as seen by the hazard rules.
    typedef struct packed {
        logic       v;
        logic       wen;
        logic [4:0] dst;
        logic       ld;
    } ent_t;

    logic clk;
    logic rst;
    logic id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic id_rs_used;
    logic id_rt_used;
    logic id_wen;
    logic [RA_W-1:0] id_dst;
    logic id_is_load;
    logic jump_en;
    logic inst_stall;
    logic mem_stall;
    logic if_en, id_en, exe_en, mem_en, wb_en;
    logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic ld_use_stall;
    logic [SEL_W-1:0] fwd_a_sel;
    logic fwd_a_ld;
    logic [SEL_W-1:0] fwd_b_sel;
    logic fwd_b_ld;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_ld_use, cnt_mem_stall, cnt_inst_stall, cnt_flush;
    int unsigned m_cnt_ld, m_cnt_mem, m_cnt_inst, m_cnt_flush;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ent_t pipe[$];
    vec_t vecs[$];

    pipe_hazard_unit #(
        .RA_W  (RA_W),
        .DEPTH (DEPTH),
        .LD_LAT(LD_LAT),
        .SEL_W (SEL_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_rs_used  (id_rs_used),
        .i_id_rt_used  (id_rt_used),
        .i_id_wen      (id_wen),
        .i_id_dst      (id_dst),
        .i_id_is_load  (id_is_load),
        .i_jump_en     (jump_en),
        .i_inst_stall  (inst_stall),
        .i_mem_stall   (mem_stall),
        .o_if_en       (if_en),
        .o_id_en       (id_en),
        .o_exe_en      (exe_en),
        .o_mem_en      (mem_en),
        .o_wb_en       (wb_en),
        .o_if_rst      (if_rst),
        .o_id_rst      (id_rst),
        .o_exe_rst     (exe_rst),
        .o_mem_rst     (mem_rst),
        .o_wb_rst      (wb_rst),
        .o_ld_use_stall(ld_use_stall),
        .o_fwd_a_sel   (fwd_a_sel),
        .o_fwd_a_ld    (fwd_a_ld),
        .o_fwd_b_sel   (fwd_b_sel),
        .o_fwd_b_ld    (fwd_b_ld)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_cnt_ld_use    (cnt_ld_use),
        .o_cnt_mem_stall (cnt_mem_stall),
        .o_cnt_inst_stall(cnt_inst_stall),
        .o_cnt_flush     (cnt_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {en[5], rst[5], ld_use, a_sel[3], a_ld, b_sel[3], b_ld},
    // stage order if, id, exe, mem, wb.
    function automatic logic [18:0] mk(input logic [4:0] en, input logic [4:0] rs,
                                       input logic lu, input logic [2:0] sa, input logic la,
                                       input logic [2:0] sb, input logic lb);
        return {en, rs, lu, sa, la, sb, lb};
    endfunction

    function automatic logic [18:0] dut_out();
        return {if_en, id_en, exe_en, mem_en, wb_en, if_rst, id_rst, exe_rst, mem_rst, wb_rst,
                ld_use_stall, fwd_a_sel, fwd_a_ld, fwd_b_sel, fwd_b_ld};
    endfunction

    function automatic in_t ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic rsu, input logic rtu, input logic wen,
                                input logic [4:0] dst, input logic ld);
        in_t x;
        x = '0;
        x.valid = v;
        x.rs = rs;
        x.rt = rt;
        x.rs_used = rsu;
        x.rt_used = rtu;
        x.wen = wen;
        x.dst = dst;
        x.is_load = ld;
        return x;
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", name, got, exp);
        end
    endtask

    // Reference model: outputs derived from the list of instructions in flight.
    function automatic logic [18:0] predict(input in_t x);
        int fa, fb;
        logic lu, ha, hb;
        logic [2:0] sa, sb;
        logic la, lb;
        logic [4:0] en, rs;
        fa = -1;
        fb = -1;
        lu = 1'b0;
        if (!x.rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ha = pipe[i].v && pipe[i].wen && pipe[i].dst == x.rs && x.rs != 0 && x.rs_used;
                hb = pipe[i].v && pipe[i].wen && pipe[i].dst == x.rt && x.rt != 0 && x.rt_used;
                if (ha && fa < 0) fa = i;
                if (hb && fb < 0) fb = i;
                if ((ha || hb) && pipe[i].ld && i < LD_LAT) lu = 1'b1;
            end
        end
        sa = (lu || fa < 0) ? 3'd0 : 3'(fa + 1);
        la = (lu || fa < 0) ? 1'b0 : pipe[fa].ld;
        sb = (lu || fb < 0) ? 3'd0 : 3'(fb + 1);
        lb = (lu || fb < 0) ? 1'b0 : pipe[fb].ld;
        if (x.rst) begin
            en = 5'b11111; rs = 5'b11111;
        end else if (x.mem_stall) begin
            en = 5'b00000; rs = 5'b00000;
        end else if (x.inst_stall || lu) begin
            en = 5'b00111; rs = 5'b00100;
        end else if (x.jump) begin
            en = 5'b11111; rs = 5'b01000;
        end else begin
            en = 5'b11111; rs = 5'b00000;
        end
        return {en, rs, lu, sa, la, sb, lb};
    endfunction

    task automatic model_update(input in_t x, input logic lu);
        ent_t e;
        if (x.rst) begin
            pipe.delete();
            for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
`ifdef HAZARD_PERF_CNT_EN
            m_cnt_ld = 0; m_cnt_mem = 0; m_cnt_inst = 0; m_cnt_flush = 0;
`endif
        end else if (x.mem_stall) begin
`ifdef HAZARD_PERF_CNT_EN
            m_cnt_mem++;
`endif
        end else begin
            if (x.inst_stall || lu) begin
                e = '0;
`ifdef HAZARD_PERF_CNT_EN
                if (x.inst_stall) m_cnt_inst++;
                else m_cnt_ld++;
`endif
            end else begin
                e = '{v: x.valid, wen: x.wen, dst: x.dst, ld: x.is_load};
`ifdef HAZARD_PERF_CNT_EN
                if (x.jump) m_cnt_flush++;
`endif
            end
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    endtask

    task automatic drive(input in_t x);
        rst        = x.rst;
        id_valid   = x.valid;
        id_rs      = x.rs;
        id_rt      = x.rt;
        id_rs_used = x.rs_used;
        id_rt_used = x.rt_used;
        id_wen     = x.wen;
        id_dst     = x.dst;
        id_is_load = x.is_load;
        jump_en    = x.jump;
        inst_stall = x.inst_stall;
        mem_stall  = x.mem_stall;
    endtask

    // Apply one cycle of inputs, compare the combinational outputs, advance.
    task automatic run_cycle(input string name, input in_t x, input logic [18:0] exp);
        logic [18:0] p;
        drive(x);
        #2;
        check(name, dut_out(), exp);
        p = predict(x);
        model_update(x, p[8]);
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string n, input in_t x, input logic [18:0] e);
        vec_t v;
        v.name = n;
        v.in   = x;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    initial begin
        in_t x;
        in_t rd;
        for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
`ifdef HAZARD_PERF_CNT_EN
        m_cnt_ld = 0; m_cnt_mem = 0; m_cnt_inst = 0; m_cnt_flush = 0;
`endif

        // Directed table; each row is one cycle following the previous one.
        x = ins(0, 0, 0, 0, 0, 0, 0, 0); x.rst = 1'b1;
        add_vec("reset", x, mk(5'h1f, 5'h1f, 0, 0, 0, 0, 0));
        add_vec("lw_r2", ins(1, 1, 2, 1, 0, 1, 2, 1), mk(5'h1f, 0, 0, 0, 0, 0, 0));
        add_vec("ld_use_stall", ins(1, 2, 4, 1, 1, 1, 3, 0),
                mk(5'b00111, 5'b00100, 1, 0, 0, 0, 0));
        add_vec("ld_fwd_mem", ins(1, 2, 4, 1, 1, 1, 3, 0), mk(5'h1f, 0, 0, 2, 1, 0, 0));
        add_vec("add_r5", ins(1, 1, 1, 1, 1, 1, 5, 0), mk(5'h1f, 0, 0, 0, 0, 0, 0));
        add_vec("sub_r5_r5", ins(1, 5, 5, 1, 1, 1, 6, 0), mk(5'h1f, 0, 0, 1, 0, 1, 0));
        add_vec("rd_r6_r0", ins(1, 6, 0, 1, 1, 1, 7, 0), mk(5'h1f, 0, 0, 1, 0, 0, 0));
        add_vec("add_r7_again", ins(1, 1, 0, 1, 0, 1, 7, 0), mk(5'h1f, 0, 0, 0, 0, 0, 0));
        add_vec("youngest_r7", ins(1, 7, 6, 1, 1, 1, 8, 0), mk(5'h1f, 0, 0, 1, 0, 3, 0));
        add_vec("write_r0", ins(1, 1, 0, 1, 0, 1, 0, 0), mk(5'h1f, 0, 0, 0, 0, 0, 0));
        add_vec("read_r0_r8", ins(1, 0, 8, 1, 1, 0, 0, 0), mk(5'h1f, 0, 0, 0, 0, 2, 0));
        x = ins(1, 0, 0, 0, 0, 0, 0, 0); x.jump = 1'b1; x.inst_stall = 1'b1;
        add_vec("jump_inst_stall", x, mk(5'b00111, 5'b00100, 0, 0, 0, 0, 0));
        x.inst_stall = 1'b0;
        add_vec("jump_taken", x, mk(5'h1f, 5'b01000, 0, 0, 0, 0, 0));

        drive(vecs[0].in);
        @(posedge clk);
        #1;
        foreach (vecs[k]) run_cycle(vecs[k].name, vecs[k].in, vecs[k].exp);

        // mem_stall for four cycles with a load sitting in MEM.
        run_cycle("lw_r9", ins(1, 1, 0, 1, 0, 1, 9, 1), mk(5'h1f, 0, 0, 0, 0, 0, 0));
        run_cycle("nop", ins(0, 0, 0, 0, 0, 0, 0, 0), mk(5'h1f, 0, 0, 0, 0, 0, 0));
        rd = ins(1, 9, 0, 1, 0, 1, 10, 0);
        rd.mem_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            run_cycle($sformatf("mem_stall_%0d", c), rd, mk(5'h00, 0, 0, 2, 1, 0, 0));
        end
        rd.mem_stall = 1'b0;
        run_cycle("mem_stall_release", rd, mk(5'h1f, 0, 0, 2, 1, 0, 0));

        // Reset asserted in the middle of a stall.
        run_cycle("lw_r2_b", ins(1, 1, 0, 1, 0, 1, 2, 1), mk(5'h1f, 0, 0, 0, 0, 0, 0));
        rd = ins(1, 2, 0, 1, 0, 1, 3, 0);
        rd.inst_stall = 1'b1;
        run_cycle("stall_before_rst", rd, mk(5'b00111, 5'b00100, 1, 0, 0, 0, 0));
        rd.rst = 1'b1;
        run_cycle("rst_mid_stall", rd, mk(5'h1f, 5'h1f, 0, 0, 0, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_after_rst", 19'({cnt_ld_use, cnt_mem_stall, cnt_inst_stall, cnt_flush} != 0),
              19'd0);
`endif
        rd.rst = 1'b0;
        rd.inst_stall = 1'b0;
        run_cycle("after_rst_read_r2", rd, mk(5'h1f, 0, 0, 0, 0, 0, 0));

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            x = '0;
            x.rst        = ($urandom_range(0, 59) == 0);
            x.valid      = ($urandom_range(0, 7) != 0);
            x.rs         = 5'($urandom_range(0, 3));
            x.rt         = 5'($urandom_range(0, 3));
            x.rs_used    = 1'($urandom_range(0, 1));
            x.rt_used    = 1'($urandom_range(0, 1));
            x.wen        = ($urandom_range(0, 3) != 0);
            x.dst        = 5'($urandom_range(0, 3));
            x.is_load    = ($urandom_range(0, 2) == 0);
            x.jump       = ($urandom_range(0, 7) == 0);
            x.inst_stall = ($urandom_range(0, 9) == 0);
            x.mem_stall  = ($urandom_range(0, 9) == 0);
            run_cycle($sformatf("random_%0d", n), x, predict(x));
        end

`ifdef HAZARD_PERF_CNT_EN
        check("cnt_ld_use", 19'(cnt_ld_use != 32'(m_cnt_ld)), 19'd0);
        check("cnt_mem_stall", 19'(cnt_mem_stall != 32'(m_cnt_mem)), 19'd0);
        check("cnt_inst_stall", 19'(cnt_inst_stall != 32'(m_cnt_inst)), 19'd0);
        check("cnt_flush", 19'(cnt_flush != 32'(m_cnt_flush)), 19'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
